// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan controller: register map, scan states, font table.
package fnd_pkg;

  localparam logic [1:0] ADDR_FCR = 2'd0;
  localparam logic [1:0] ADDR_FDR = 2'd1;
  localparam logic [1:0] ADDR_FMR = 2'd2;
  localparam logic [1:0] ADDR_FPR = 2'd3;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_state_t;

  // Active-low seven-segment glyphs; bit7 (dp) is left off in every entry.
  function automatic logic [7:0] font_lut(input logic [3:0] value);
    logic [7:0] seg;
    case (value)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  function automatic scan_state_t next_digit(input scan_state_t state);
    scan_state_t nxt;
    case (state)
      DIG0:    nxt = DIG1;
      DIG1:    nxt = DIG2;
      DIG2:    nxt = DIG3;
      default: nxt = DIG0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fnd_prescaler.sv
// Digit-slot prescaler: counts 0..DIV-1 while enabled and pulses tick on the last count.
module fnd_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_reg;

  assign tick = enable && (count_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= tick ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// APB-programmed 4-digit seven-segment scan controller (one APB wait state).
// Optional per-digit decimal point register enabled by defining FND_DOT_EN.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic [3:0]  fnd_comm,
  output logic [7:0]  fnd_font
);

  logic        access, wr_commit, rd_load;
  logic        ready_reg;
  logic [31:0] prdata_reg, rdata_next;
  logic        en_reg;
  logic [15:0] fdr_reg;
  logic [3:0]  fmr_reg;
  logic [3:0]  fpr;
  logic        dot;
  scan_state_t state_reg, state_next;
  logic [1:0]  state_idx;
  logic        slot_tick;
  logic [3:0]  state_hot, digit_on;
  logic [3:0]  nibble;
  logic [7:0]  glyph;
  logic [3:0]  comm_reg, comm_next;
  logic [7:0]  font_reg, font_next;
  logic        unused_ok;

  // The access phase is accepted only while PREADY is low, giving a single wait state.
  assign access    = PSEL & PENABLE & ~ready_reg;
  assign wr_commit = access & PWRITE;
  assign rd_load   = access & ~PWRITE;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ready_reg  <= 1'b0;
      prdata_reg <= '0;
    end else begin
      ready_reg <= access;
      if (rd_load) prdata_reg <= rdata_next;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      en_reg  <= 1'b0;
      fdr_reg <= '0;
      fmr_reg <= '0;
    end else if (wr_commit) begin
      case (PADDR[3:2])
        ADDR_FCR: en_reg  <= PWDATA[0];
        ADDR_FDR: fdr_reg <= PWDATA[15:0];
        ADDR_FMR: fmr_reg <= PWDATA[3:0];
        default:  ;
      endcase
    end
  end

`ifdef FND_DOT_EN
  logic [3:0] fpr_reg;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      fpr_reg <= '0;
    end else if (wr_commit && (PADDR[3:2] == ADDR_FPR)) begin
      fpr_reg <= PWDATA[3:0];
    end
  end

  assign fpr = fpr_reg;
  assign dot = ~|(fpr & state_hot);
`else
  assign fpr = '0;
  assign dot = 1'b1;
`endif

  always_comb begin
    rdata_next = '0;
    case (PADDR[3:2])
      ADDR_FCR: rdata_next[0]    = en_reg;
      ADDR_FDR: rdata_next[15:0] = fdr_reg;
      ADDR_FMR: rdata_next[3:0]  = fmr_reg;
      ADDR_FPR: rdata_next[3:0]  = fpr;
      default:  ;
    endcase
  end

  // Holding the prescaler in clear while disabled makes the first slot after enable full length.
  fnd_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk    (PCLK),
    .rst    (PRESET),
    .enable (en_reg),
    .clear  (~en_reg),
    .tick   (slot_tick)
  );

  always_comb begin
    state_next = state_reg;
    if (!en_reg) begin
      state_next = DIG0;
    end else if (slot_tick) begin
      state_next = next_digit(state_reg);
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_reg <= DIG0;
    else        state_reg <= state_next;
  end

  assign state_idx = state_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign state_hot[gi] = (state_idx == 2'(gi));
    end
  endgenerate

  assign digit_on  = state_hot & fmr_reg & {4{en_reg}};
  assign nibble    = fdr_reg[{state_idx, 2'b00} +: 4];
  assign glyph     = font_lut(nibble);
  assign comm_next = ~digit_on;
  assign font_next = (|digit_on) ? {dot, glyph[6:0]} : 8'hFF;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      comm_reg <= 4'b1111;
      font_reg <= 8'hFF;
    end else begin
      comm_reg <= comm_next;
      font_reg <= font_next;
    end
  end

  assign PREADY   = ready_reg;
  assign PRDATA   = prdata_reg;
  assign fnd_comm = comm_reg;
  assign fnd_font = font_reg;

  assign unused_ok = ^{PWDATA[31:16], PADDR[1:0], glyph[7]};

endmodule

// File: doc/fnd_scan_ctrl.md
FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 The block SHALL take parameter REFRESH_DIV, default 100000: PCLK cycles per digit slot, minimum 2.
REQ-002 The block SHALL have port PCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port PRESET, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port PADDR, input, 4 bits: APB byte address; only [3:2] is decoded.
REQ-005 The block SHALL have port PWDATA, input, 32 bits: APB write data.
REQ-006 The block SHALL have ports PWRITE, PENABLE and PSEL, each input, 1 bit: APB write strobe, enable and select.
REQ-007 The block SHALL have port PRDATA, output, 32 bits: APB read data, registered.
REQ-008 The block SHALL have port PREADY, output, 1 bit: APB ready, registered.
REQ-009 The block SHALL have port fnd_comm, output, 4 bits: digit select, active-low, registered.
REQ-010 The block SHALL have port fnd_font, output, 8 bits: segments, active-low, bit7 = dp, registered.

Function
REQ-011 Registers SHALL be: 0x0 FCR[0] = EN; 0x4 FDR[15:0] = four hex nibbles (digit0 = [3:0]); 0x8 FMR[3:0] = digit enable mask; 0xC FPR[3:0] = per-digit dp.
REQ-012 Unused register bits SHALL ignore writes and read 0.
REQ-013 APB: when PSEL&PENABLE&!PREADY, PREADY SHALL be 1 next cycle for exactly one cycle, then 0 (one wait state).
REQ-014 A write SHALL commit once, on the same edge that sets PREADY.
REQ-015 On a read, PRDATA SHALL load the addressed register on the same edge that sets PREADY; PRDATA SHALL hold its value otherwise.
REQ-016 Scan FSM states SHALL be DIG0->DIG1->DIG2->DIG3->DIG0, advancing when the prescaler reaches REFRESH_DIV-1; the prescaler then wraps to 0.
REQ-017 While EN=0, the prescaler SHALL be held at 0 and the FSM held in DIG0.
REQ-018 When EN goes 1, scanning SHALL start in DIG0 with a full REFRESH_DIV-cycle slot.
REQ-019 Outputs SHALL be registered from the current state and registers, with 1-cycle latency after a state change or register commit.
REQ-020 In DIGn with EN=1 and FMR[n]=1: fnd_comm SHALL be ~(1<<n), fnd_font[6:0] SHALL be FONT(FDR nibble n), and fnd_font[7] SHALL follow REQ-025/026.
REQ-021 When EN=0 or FMR[n]=0: fnd_comm SHALL be 4'b1111 and fnd_font SHALL be 8'hFF.
REQ-022 A write to FDR, FMR or FPR mid-slot SHALL take effect 1 cycle after commit, without restarting the prescaler or changing the FSM state.
REQ-023 A write of EN=0 mid-slot SHALL blank the outputs 1 cycle after commit.

Reset
REQ-024 PRESET SHALL immediately force: all registers 0, prescaler 0, FSM DIG0, PREADY 0, PRDATA 0, fnd_comm 4'b1111, fnd_font 8'hFF; an APB transfer in flight SHALL be aborted.

Configuration
REQ-025 With FND_DOT_EN defined, FPR SHALL be implemented and fnd_font[7] SHALL be ~FPR[n] in enabled DIGn.
REQ-026 Without FND_DOT_EN, FPR SHALL ignore writes and read 0, and fnd_font[7] SHALL always be 1.

Structure
REQ-027 Package fnd_pkg SHALL hold the FONT table (0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E), register offset constants and enum scan_state_t.
REQ-028 Sub-module fnd_prescaler SHALL generate the slot tick (inputs: enable and clear).

Verification (bench uses REFRESH_DIV=4)
REQ-029 Assert PRESET mid-operation -> fnd_comm=1111, fnd_font=FF, PREADY=0 and PRDATA=0 immediately.
REQ-030 Write FDR=0xABCD1234, then read 0x4 -> PREADY high for exactly 1 cycle on each transfer, and PRDATA=0x00001234.
REQ-031 FCR=1, FMR=F -> fnd_comm 1110/1101/1011/0111 for 4 cycles each, with fnd_font 99/B0/A4/F9 respectively, repeating.
REQ-032 FMR=5 -> digit1 and digit3 slots show 1111/FF; digits 0 and 2 show as in REQ-031.
REQ-033 Write FCR=0 during DIG2 -> blanked 1 cycle after commit; write FCR=1 -> DIG0 with a full 4-cycle slot.
REQ-034 FPR=2 -> with FND_DOT_EN, the digit1 font is 30; without it, the digit1 font stays B0 and FPR reads 0.
